// File: rtl/popcount_sched_pkg.sv
// Shared constants and FSM state type for the popcount scheduler.
package popcount_sched_pkg;

    localparam int NREQ   = 4;   // requesters sharing the datapath
    localparam int W      = 64;  // beat width
    localparam int ACC_W  = 16;  // accumulated count width
    localparam int CNT_W  = 7;   // per-beat popcount width (0..64)
    localparam int BEAT_W = 8;   // beat counter width, saturates at 255

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RESP
    } state_t;

endpackage

// File: rtl/popcount64.sv
// Purely combinational ones counter for one data beat.
module popcount64
    import popcount_sched_pkg::*;
#(
    parameter int W = popcount_sched_pkg::W
) (
    input  logic [W-1:0]     data,
    output logic [CNT_W-1:0] count
);

    // sum every bit of the beat
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CNT_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_sched.sv
// Round-robin scheduler that accumulates the popcount of one requester's
// multi-beat transaction and returns the total on a response handshake.
module popcount_sched
    import popcount_sched_pkg::*;
#(
    parameter int NREQ  = popcount_sched_pkg::NREQ,
    parameter int W     = popcount_sched_pkg::W,
    parameter int ACC_W = popcount_sched_pkg::ACC_W,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [ACC_W-1:0]    rsp_count,
    output logic [BEAT_W-1:0]   rsp_beats,
    output logic                rsp_sat,
    output logic                busy
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, owner, grant;
    logic                grant_vld;
    logic [ACC_W-1:0]    acc, acc_base, acc_nxt;
    logic [ACC_W:0]      sum;
    logic                ovf;
    logic [BEAT_W-1:0]   beats, beats_nxt;
    logic                sat, sat_nxt;
    logic [NREQ-1:0]     ready_int;
    logic [W-1:0]        sel_data;
    logic [CNT_W-1:0]    pc;
    logic                accept, accept_last;
    logic                in_resp;

    // round-robin pick: first valid requester at or after rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    // ready: arbitration winner in IDLE, locked to owner in BURST, none in RESP
    always_comb begin
        ready_int = '0;
        if (!rst) begin
            case (state)
                IDLE:    if (grant_vld) ready_int[grant] = 1'b1;
                BURST:   ready_int[owner] = 1'b1;
                default: ready_int = '0;
            endcase
        end
    end

    assign req_ready   = ready_int;
    assign accept      = |(req_valid & ready_int);
    assign accept_last = |(req_valid & ready_int & req_last);

    // one-hot mux of the granted beat into the single counter
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready_int[i]) sel_data = sel_data | req_data[i*W +: W];
        end
    end

    popcount64 #(.W(W)) u_popcount (
        .data  (sel_data),
        .count (pc)
    );

    // saturating accumulate; the first beat of a transaction loads instead of adding
    always_comb begin
        acc_base  = (state == IDLE) ? '0 : acc;
        sum       = {1'b0, acc_base} + (ACC_W+1)'(pc);
        ovf       = sum[ACC_W];
        acc_nxt   = ovf ? '1 : sum[ACC_W-1:0];
        sat_nxt   = (state == IDLE) ? ovf : (sat | ovf);
        if (state == IDLE)       beats_nxt = BEAT_W'(1);
        else if (&beats)         beats_nxt = beats;
        else                     beats_nxt = beats + BEAT_W'(1);
    end

    // next state: burst until the owner's last beat, hold result until accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = accept_last ? RESP : BURST;
            BURST:   if (accept_last) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, owner, accumulator and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            acc    <= '0;
            beats  <= '0;
            sat    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc   <= acc_nxt;
                beats <= beats_nxt;
                sat   <= sat_nxt;
                if (state == IDLE) owner <= grant;
            end
            if (state == RESP && rsp_ready) begin
                rr_ptr <= (owner == ID_W'(NREQ-1)) ? '0 : owner + 1'b1;
            end
        end
    end

    // result fields only show while a response is pending
    assign in_resp   = (state == RESP) && !rst;
    assign rsp_valid = in_resp;
    assign rsp_id    = in_resp ? owner : '0;
    assign rsp_count = in_resp ? acc : '0;
    assign rsp_beats = in_resp ? beats : '0;
    assign rsp_sat   = in_resp ? sat : 1'b0;
    assign busy      = !rst && (state != IDLE);

endmodule

// File: tb/tb_popcount_sched.sv
// Directed + randomized bench with a transaction-level reference model.
module tb_popcount_sched;

    localparam int NREQ  = 4;
    localparam int W     = 64;
    localparam int ACC_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [NREQ*W-1:0] req_data;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [ACC_W-1:0]  rsp_count;
    logic [7:0]        rsp_beats;
    logic              rsp_sat, busy;

    int checks = 0;
    int errors = 0;

    popcount_sched #(.NREQ(NREQ), .W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_beats (rsp_beats),
        .rsp_sat   (rsp_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // reference: saturating totals from plain arithmetic
    function automatic longint sat_cnt(input longint tot);
        return (tot > 65535) ? 65535 : tot;
    endfunction

    function automatic longint sat_beats(input longint n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_rsp_count"}, 64'(rsp_count), 64'd0);
        chk({tag, "_rsp_beats"}, 64'(rsp_beats), 64'd0);
        chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
        chk({tag, "_rsp_sat"},   64'(rsp_sat),   64'd0);
    endtask

    // present one beat from requester id and wait (bounded) for its acceptance
    task automatic beat(input int id, input logic [63:0] d, input bit last, input string tag);
        int c;
        req_valid[id]        = 1'b1;
        req_data[id*W +: W]  = d;
        req_last[id]         = last;
        c = 0;
        #1;
        while (!req_ready[id] && c < 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'(oh(id)));
        chk({tag, "_no_rsp"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic noise(input int id, input bit on);
        for (int j = 0; j < NREQ; j++) begin
            if (j != id) begin
                req_valid[j]       = on ? 1'($urandom) : 1'b0;
                req_data[j*W +: W] = {$urandom, $urandom};
                req_last[j]        = 1'($urandom);
            end
        end
    endtask

    task automatic check_out(input string tag, input int id, input longint cnt,
                             input longint nb, input bit s);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_id"},    64'(rsp_id),    64'(id));
        chk({tag, "_rsp_count"}, 64'(rsp_count), 64'(cnt));
        chk({tag, "_rsp_beats"}, 64'(rsp_beats), 64'(nb));
        chk({tag, "_rsp_sat"},   64'(rsp_sat),   64'(s));
        chk({tag, "_ready_off"}, 64'(req_ready), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd1);
    endtask

    // check the pending response, hold it under backpressure, then hand it off
    task automatic finish_rsp(input string tag, input int id, input longint tot,
                              input longint n, input int hold, input logic [3:0] keep);
        check_out(tag, id, sat_cnt(tot), sat_beats(n), tot > 65535);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check_out({tag, "_hold"}, id, sat_cnt(tot), sat_beats(n), tot > 65535);
        end
        req_valid = req_valid & keep;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle"},     64'(busy),      64'd0);
    endtask

    logic [63:0] dd [NREQ];
    logic [63:0] d;
    longint      tot;
    int          id, n, c;

    initial begin
        // reset with every requester knocking
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '1;
        req_data  = {8{$urandom}};
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_quiet_busy",  64'(busy),      64'd0);
            chk("idle_quiet_ready", 64'(req_ready), 64'd0);
        end

        // round-robin with all four requesters sending single beats
        for (int i = 0; i < NREQ; i++) begin
            dd[i] = {$urandom, $urandom};
            req_data[i*W +: W] = dd[i];
        end
        req_valid = '1;
        req_last  = '1;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            c = 0;
            #1;
            while (req_ready == '0 && c < 20) begin
                @(negedge clk);
                #1;
                c++;
            end
            chk("rr_grant", 64'(req_ready), 64'(oh(g % NREQ)));
            @(negedge clk);
            chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rr_rsp_id",    64'(rsp_id),    64'(g % NREQ));
            chk("rr_rsp_count", 64'(rsp_count), 64'($countones(dd[g % NREQ])));
            chk("rr_rsp_beats", 64'(rsp_beats), 64'd1);
            @(negedge clk);
        end
        req_valid = '0;
        req_last  = '0;
        rsp_ready = 1'b0;

        // single beat from requester 2
        beat(2, 64'hFFFF_0000_FFFF_0000, 1'b1, "single");
        finish_rsp("single", 2, 32, 1, 0, 4'b0000);

        // 4-beat burst from requester 0 while requester 1 waits, with backpressure
        req_valid[1]       = 1'b1;
        req_data[1*W +: W] = 64'h0F0F_0F0F_0000_0001;
        req_last[1]        = 1'b1;
        for (int b = 0; b < 4; b++) beat(0, '1, b == 3, "burst");
        finish_rsp("burst", 0, 256, 4, 5, 4'b0010);
        #1;
        chk("next_grant_r1", 64'(req_ready), 64'(oh(1)));
        beat(1, 64'h0F0F_0F0F_0000_0001, 1'b1, "r1_after");
        finish_rsp("r1_after", 1, 17, 1, 0, 4'b0000);

        // randomized transactions with stalls, noise and backpressure
        for (int t = 0; t < 25; t++) begin
            id  = int'($urandom_range(0, NREQ-1));
            n   = int'($urandom_range(1, 6));
            tot = 0;
            for (int b = 0; b < n; b++) begin
                case ($urandom_range(0, 3))
                    0:       d = '0;
                    1:       d = '1;
                    default: d = {$urandom, $urandom};
                endcase
                tot += $countones(d);
                if (b > 0) begin
                    noise(id, 1'b1);
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[id] = 1'b0;
                        #1;
                        chk("stall_ready", 64'(req_ready), 64'(oh(id)));
                        @(negedge clk);
                        chk("stall_busy", 64'(busy),      64'd1);
                        chk("stall_rsp",  64'(rsp_valid), 64'd0);
                        noise(id, 1'b1);
                    end
                end
                beat(id, d, b == n - 1, "rnd");
            end
            finish_rsp("rnd", id, tot, n, int'($urandom_range(0, 3)), 4'b0000);
        end

        // saturation: 1100 all-ones beats from requester 3
        for (int b = 0; b < 1100; b++) beat(3, '1, b == 1099, "satb");
        finish_rsp("sat", 3, 1100 * 64, 1100, 1, 4'b0000);

        // reset in the middle of a burst discards it
        beat(1, '1, 1'b0, "mid");
        beat(1, '1, 1'b0, "mid");
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '1;
        rsp_ready = 1'b1;
        #1;
        check_zero("rst_mid_now");
        @(negedge clk);
        check_zero("rst_mid");
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        rsp_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            chk("post_rst_busy",   64'(busy),      64'd0);
        end
        d = 64'h8000_0000_0000_0003;
        req_data[0*W +: W] = d;
        req_data[1*W +: W] = '1;
        req_valid = 4'b1111;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'(oh(0)));
        req_valid = 4'b0011;
        beat(0, d, 1'b1, "fresh");
        finish_rsp("fresh", 0, 3, 1, 0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
